guard_rst_sequencer: RTL

- Recovery controller that sequences the write/read guards and the downstream AXI slave after a guard timeout.
- Collects reset requests from write_guard and read_guard, then isolates the slave port and waits for drain.
- Drives an active-low reset pulse to the slave, then pulses reset_clear back to both guards so they re-arm.
- Sits between the guards, the AXI isolate stage and the slave reset domain. Owns the guard irq line.

---
 rtl/guard_rst_sequencer_pkg.sv | 27 ++
 rtl/seq_down_counter.sv | 40 ++++
 rtl/guard_rst_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/guard_rst_sequencer_pkg.sv
// Shared types for the guard reset sequencer: FSM state encoding, counter type, cause record.
package guard_rst_sequencer_pkg;

   localparam int unsigned SeqCntWidth = 16;

   typedef enum logic [2:0] {
      StIdle,
      StIsolate,
      StReset,
      StSettle,
      StClear,
      StCooldown
   } seq_state_e;

   typedef logic [SeqCntWidth-1:0] seq_cnt_t;

   // Packed so that bit0 = wr and bit1 = rd when driven straight onto cause_o.
   typedef struct packed {
      logic rd;
      logic wr;
   } cause_t;

   function automatic logic any_req(input cause_t c);
      return c.rd | c.wr;
   endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that stops at zero. Loads of zero are raised to one so a
// loaded count always spans at least one cycle; done flags the last counted cycle.
module seq_down_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

   logic [Width-1:0] count;
   logic [Width-1:0] count_next;

   // Next count: load takes priority over decrement, decrement never wraps below zero.
   always_comb begin
      count_next = count;
      if (load) begin
         count_next = (load_val == '0) ? One : load_val;
      end else if (dec && (count != '0)) begin
         count_next = count - One;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

   assign done = (count <= One);

endmodule

// File: rtl/guard_rst_sequencer.sv
// guard_rst_sequencer: after a guard timeout, isolates the slave port, waits for drain,
// pulses the slave reset, lets it settle, then clears both guards and owns the guard irq.
// Optional feature: define GUARD_RST_SEQ_DRAIN_TIMEOUT_EN to bound the drain wait in
// ISOLATE and add the sticky drain_to_o status output.
module guard_rst_sequencer
   import guard_rst_sequencer_pkg::*;
#(
   parameter int unsigned CntWidth     = 16,
   parameter int unsigned DrainTimeout = 1024,
   parameter int unsigned SettleCycles = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                wr_reset_req_i,
   input  logic                rd_reset_req_i,
   input  logic                isolated_i,
   input  logic [CntWidth-1:0] rst_hold_i,
   input  logic                irq_ack_i,
   output logic                isolate_o,
   output logic                slv_rst_no,
   output logic                reset_clear_o,
   output logic                irq_o,
   output logic [1:0]          cause_o,
   output logic                busy_o
`ifdef GUARD_RST_SEQ_DRAIN_TIMEOUT_EN
   ,
   output logic                drain_to_o
`endif
);

   if (SettleCycles < 1 || DrainTimeout < 2) begin : gen_cfg_check
      $error("guard_rst_sequencer: SettleCycles must be >= 1 and DrainTimeout >= 2");
   end

   localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SettleCycles);

   seq_state_e          state;
   seq_state_e          state_next;
   cause_t              req;
   cause_t              cause;
   cause_t              cause_next;
   logic                irq;
   logic                irq_next;
   logic                start;
   logic                go_reset;
   logic                hold_load;
   logic                hold_dec;
   logic                hold_done;
   logic [CntWidth-1:0] hold_load_val;

   assign req.wr = wr_reset_req_i;
   assign req.rd = rd_reset_req_i;

   // A new sequence only starts from IDLE; COOLDOWN deliberately ignores the stale request.
   assign start = (state == StIdle) && any_req(req);

   // One counter serves both the RESET hold and the SETTLE wait. rst_hold_i is sampled only
   // on the ISOLATE->RESET edge; SettleCycles is loaded as RESET finishes.
   assign hold_load     = ((state == StIsolate) && go_reset) || ((state == StReset) && hold_done);
   assign hold_load_val = (state == StReset) ? SettleLoad : rst_hold_i;
   assign hold_dec      = (state == StReset) || (state == StSettle);

   seq_down_counter #(
      .Width (CntWidth)
   ) u_hold_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (hold_load),
      .load_val (hold_load_val),
      .dec      (hold_dec),
      .done     (hold_done)
   );

`ifdef GUARD_RST_SEQ_DRAIN_TIMEOUT_EN
   localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(DrainTimeout);

   logic drain_done;
   logic drain_expired;
   logic drain_to;
   logic drain_to_next;

   seq_down_counter #(
      .Width (CntWidth)
   ) u_drain_cnt (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (start),
      .load_val (DrainLoad),
      .dec      (state == StIsolate),
      .done     (drain_done)
   );

   // Loaded with DrainTimeout on ISOLATE entry, so done marks the DrainTimeout-th ISOLATE cycle.
   assign drain_expired = (state == StIsolate) && drain_done;
   assign go_reset      = isolated_i || drain_expired;

   // Sticky drain timeout flag; a new timeout wins over a coincident acknowledge.
   always_comb begin
      drain_to_next = irq_ack_i ? 1'b0 : drain_to;
      if (drain_expired && !isolated_i) begin
         drain_to_next = 1'b1;
      end
   end

   // Drain timeout status register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drain_to <= 1'b0;
      end else begin
         drain_to <= drain_to_next;
      end
   end

   assign drain_to_o = drain_to;
`else
   assign go_reset = isolated_i;
`endif

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         StIdle:     if (start)     state_next = StIsolate;
         StIsolate:  if (go_reset)  state_next = StReset;
         StReset:    if (hold_done) state_next = StSettle;
         StSettle:   if (hold_done) state_next = StClear;
         StClear:    state_next = StCooldown;
         StCooldown: state_next = StIdle;
         default:    state_next = StIdle;
      endcase
   end

   // FSM outputs, decoded purely from state so an async reset clears them at once.
   always_comb begin
      isolate_o     = 1'b0;
      slv_rst_no    = 1'b1;
      reset_clear_o = 1'b0;
      busy_o        = (state != StIdle);
      unique case (state)
         StIdle:     ;
         StIsolate:  isolate_o = 1'b1;
         StReset: begin
            isolate_o  = 1'b1;
            slv_rst_no = 1'b0;
         end
         StSettle:   isolate_o = 1'b1;
         StClear: begin
            isolate_o     = 1'b1;
            reset_clear_o = 1'b1;
         end
         StCooldown: ;
         default:    ;
      endcase
   end

   // Sticky irq and cause: requests are accumulated in every state, irq is raised when a
   // sequence starts, and a set in the same cycle as the acknowledge wins.
   always_comb begin
      irq_next   = irq_ack_i ? 1'b0 : irq;
      cause_next = irq_ack_i ? cause_t'(2'b00) : cause;
      cause_next = cause_next | req;
      if (start) begin
         irq_next = 1'b1;
      end
   end

   // irq and cause registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq   <= 1'b0;
         cause <= cause_t'(2'b00);
      end else begin
         irq   <= irq_next;
         cause <= cause_next;
      end
   end

   assign irq_o   = irq;
   assign cause_o = cause;

endmodule
